// File: rtl/stepmotor_odometer.sv
// Stepper coil-pattern odometer: per-wheel signed position, step progress and a
// "move N steps" handshake. Define STEPMOTOR_ODOM_FILTER_EN to add a two-sample glitch filter.
module stepmotor_odometer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       phase_left,
    input  logic [3:0]       phase_right,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic             done,
    input  logic             done_ack,
    input  logic             clr_pos,
    output logic [CNT_W-1:0] pos_left,
    output logic [CNT_W-1:0] pos_right,
    output logic [CNT_W-1:0] prog_left,
    output logic [CNT_W-1:0] prog_right,
    output logic             err_left,
    output logic             err_right
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           r_state;
    logic             r_cmd_ready;
    logic             r_done;
    logic [CNT_W-1:0] r_target;
    logic             w_cmd_acc;

    // Index 0 is the left wheel, index 1 the right wheel.
    logic [1:0][3:0]       w_phase;
    logic [1:0][CNT_W-1:0] w_pos;
    logic [1:0][CNT_W-1:0] w_prog;
    logic [1:0]            w_err;

    assign w_phase   = {phase_right, phase_left};
    assign w_cmd_acc = (r_state == ST_IDLE) && cmd_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wheel
            logic [3:0]       r_s1;
            logic [3:0]       r_s2;
            logic [3:0]       r_ref;
            logic             r_ref_vld;
            logic             r_err;
            logic [CNT_W-1:0] r_pos;
            logic [CNT_W-1:0] r_prog;
            logic             w_cand_vld;
            logic [3:0]       w_next;
            logic [3:0]       w_prev;
            logic             w_act;
            logic             w_load;
            logic             w_fwd;
            logic             w_bwd;
            logic             w_bad;

`ifdef STEPMOTOR_ODOM_FILTER_EN
            logic [3:0] r_s3;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s3 <= 4'b0000;
                end else begin
                    r_s3 <= r_s2;
                end
            end

            assign w_cand_vld = (r_s2 == r_s3);
`else
            assign w_cand_vld = 1'b1;
`endif

            // Forward rotates the one-hot left; reverse rotates it right.
            assign w_next = {r_ref[2:0], r_ref[3]};
            assign w_prev = {r_ref[0], r_ref[3:1]};
            assign w_act  = w_cand_vld && (r_s2 != 4'b0000) && (r_s2 != r_ref);
            assign w_load = w_act && !r_ref_vld && $onehot(r_s2);
            assign w_fwd  = w_act && r_ref_vld && (r_s2 == w_next);
            assign w_bwd  = w_act && r_ref_vld && (r_s2 == w_prev);
            assign w_bad  = w_act && !w_load && !w_fwd && !w_bwd;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1      <= 4'b0000;
                    r_s2      <= 4'b0000;
                    r_ref     <= 4'b0000;
                    r_ref_vld <= 1'b0;
                    r_err     <= 1'b0;
                    r_pos     <= '0;
                    r_prog    <= '0;
                end else begin
                    r_s1 <= w_phase[gi];
                    r_s2 <= r_s1;

                    if (w_load || w_fwd || w_bwd) begin
                        r_ref <= r_s2;
                    end
                    if (w_load) begin
                        r_ref_vld <= 1'b1;
                    end

                    if (clr_pos) begin
                        r_pos <= '0;
                    end else if (w_fwd) begin
                        r_pos <= r_pos + CNT_W'(1);
                    end else if (w_bwd) begin
                        r_pos <= r_pos - CNT_W'(1);
                    end

                    // A newly accepted command restarts progress, even over a same-cycle step.
                    if (w_cmd_acc) begin
                        r_prog <= '0;
                    end else if ((w_fwd || w_bwd) && (r_prog != '1)) begin
                        r_prog <= r_prog + CNT_W'(1);
                    end

                    if (w_cmd_acc) begin
                        r_err <= 1'b0;
                    end else if (w_bad) begin
                        r_err <= 1'b1;
                    end
                end
            end

            assign w_pos[gi]  = r_pos;
            assign w_prog[gi] = r_prog;
            assign w_err[gi]  = r_err;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_target    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_target    <= cmd_steps;
                        r_state     <= ST_RUN;
                        r_cmd_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if ((w_prog[0] >= r_target) && (w_prog[1] >= r_target)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (done_ack) begin
                        r_state     <= ST_IDLE;
                        r_done      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign done       = r_done;
    assign pos_left   = w_pos[0];
    assign pos_right  = w_pos[1];
    assign prog_left  = w_prog[0];
    assign prog_right = w_prog[1];
    assign err_left   = w_err[0];
    assign err_right  = w_err[1];

endmodule
